// File: rtl/frogg_pkg.sv
// Shared Frogg definitions: grid geometry, spawn cell and direction codes.
// Used by the frog movement stage, sprite windows and car/collision logic.
package frogg_pkg;

    localparam int c_GRID_COLS  = 20;
    localparam int c_GRID_ROWS  = 15;
    localparam int c_CELL_SIZE  = 32;
    localparam int c_CELL_SHIFT = $clog2(c_CELL_SIZE);
    localparam int c_START_COL  = 9;
    localparam int c_START_ROW  = 14;

    typedef enum logic [2:0] {
        DIR_NONE = 3'd0,
        DIR_UP   = 3'd1,
        DIR_DN   = 3'd2,
        DIR_LT   = 3'd3,
        DIR_RT   = 3'd4
    } dir_e;

    // Fixed priority Up > Dn > Lt > Rt; only one direction survives.
    function automatic dir_e pick_dir(
        input logic up,
        input logic dn,
        input logic lt,
        input logic rt
    );
        dir_e d;
        if (up)      d = DIR_UP;
        else if (dn) d = DIR_DN;
        else if (lt) d = DIR_LT;
        else if (rt) d = DIR_RT;
        else         d = DIR_NONE;
        return d;
    endfunction

endpackage

// File: rtl/frog_sprite_window.sv
// Registered rectangle hit test: is the current VGA pixel inside a
// c_CELL_SIZE square whose top-left corner is (x, y)?
module frog_sprite_window
    import frogg_pkg::*;
(
    input  logic       i_Clk,
    input  logic       i_Rst_N,
    input  logic [9:0] i_X,
    input  logic [9:0] i_Y,
    input  logic [9:0] i_Col_Count,
    input  logic [9:0] i_Row_Count,
    output logic       o_Draw
);

    // 11-bit arithmetic so the right/bottom edge never wraps.
    logic [10:0] col_w;
    logic [10:0] row_w;
    logic [10:0] x_lo;
    logic [10:0] y_lo;
    logic [10:0] x_hi;
    logic [10:0] y_hi;
    logic        hit;

    assign col_w = {1'b0, i_Col_Count};
    assign row_w = {1'b0, i_Row_Count};
    assign x_lo  = {1'b0, i_X};
    assign y_lo  = {1'b0, i_Y};
    assign x_hi  = x_lo + 11'(c_CELL_SIZE);
    assign y_hi  = y_lo + 11'(c_CELL_SIZE);

    assign hit = (col_w >= x_lo) && (col_w < x_hi)
              && (row_w >= y_lo) && (row_w < y_hi);

    // One-cycle registered strobe, aligned to the pixel after the counts.
    always_ff @(posedge i_Clk or negedge i_Rst_N) begin
        if (!i_Rst_N) begin
            o_Draw <= 1'b0;
        end else begin
            o_Draw <= hit;
        end
    end

endmodule

// File: rtl/frog_hop_ctrl.sv
// Frog movement stage: button edges become grid hops with cooldown,
// displayed position latched at vblank, plus the frog draw strobe.
module frog_hop_ctrl
    import frogg_pkg::*;
#(
    parameter int c_ACTIVE_ROWS  = 480,
    parameter int c_HOP_COOLDOWN = 2500000
) (
    input  logic       i_Clk,
    input  logic       i_Rst_N,
    input  logic       i_Game_Active,
    input  logic       i_Respawn,
    input  logic       i_Up,
    input  logic       i_Dn,
    input  logic       i_Lt,
    input  logic       i_Rt,
    input  logic [9:0] i_Col_Count,
    input  logic [9:0] i_Row_Count,
    output logic [9:0] o_Frog_X,
    output logic [9:0] o_Frog_Y,
    output logic       o_Draw_Frog,
    output logic       o_Hop,
    output logic       o_At_Top
);

    localparam int CW = $clog2(c_HOP_COOLDOWN + 1);

    localparam logic [0:0] S_READY = 1'b0;
    localparam logic [0:0] S_COOL  = 1'b1;

    localparam logic [4:0]    SPAWN_COL = 5'(c_START_COL);
    localparam logic [3:0]    SPAWN_ROW = 4'(c_START_ROW);
    localparam logic [4:0]    COL_MAX   = 5'(c_GRID_COLS - 1);
    localparam logic [3:0]    ROW_MAX   = 4'(c_GRID_ROWS - 1);
    localparam logic [CW-1:0] CNT_LOAD  = CW'(c_HOP_COOLDOWN - 1);

    logic          up_q;
    logic          dn_q;
    logic          lt_q;
    logic          rt_q;
    logic [4:0]    col_q;
    logic [3:0]    row_q;
    logic [4:0]    disp_col;
    logic [3:0]    disp_row;
    logic [0:0]    state;
    logic [CW-1:0] cnt;

    dir_e       req;
    logic       hop_ok;
    logic [4:0] col_n;
    logic [3:0] row_n;
    logic       vblank;

    // Pick the winning edge and the clamped target cell.
    always_comb begin
        req = pick_dir(i_Up & ~up_q, i_Dn & ~dn_q,
                       i_Lt & ~lt_q, i_Rt & ~rt_q);
        col_n = col_q;
        row_n = row_q;
        unique case (req)
            DIR_UP: if (row_q != 4'd0) row_n = row_q - 4'd1;
            DIR_DN: if (row_q != ROW_MAX) row_n = row_q + 4'd1;
            DIR_LT: if (col_q != 5'd0) col_n = col_q - 5'd1;
            DIR_RT: if (col_q != COL_MAX) col_n = col_q + 5'd1;
            default: ;
        endcase
        hop_ok = (state == S_READY) && i_Game_Active
              && (req != DIR_NONE);
    end

    // Button history, logical cell, hop FSM and cooldown counter.
    always_ff @(posedge i_Clk or negedge i_Rst_N) begin
        if (!i_Rst_N) begin
            up_q     <= 1'b0;
            dn_q     <= 1'b0;
            lt_q     <= 1'b0;
            rt_q     <= 1'b0;
            col_q    <= SPAWN_COL;
            row_q    <= SPAWN_ROW;
            state    <= S_READY;
            cnt      <= '0;
            o_Hop    <= 1'b0;
            o_At_Top <= 1'b0;
        end else begin
            up_q     <= i_Up;
            dn_q     <= i_Dn;
            lt_q     <= i_Lt;
            rt_q     <= i_Rt;
            o_Hop    <= 1'b0;
            o_At_Top <= (row_q == 4'd0);
            if (i_Respawn) begin
                col_q <= SPAWN_COL;
                row_q <= SPAWN_ROW;
                state <= S_READY;
                cnt   <= '0;
            end else if (hop_ok) begin
                col_q <= col_n;
                row_q <= row_n;
                o_Hop <= 1'b1;
                state <= S_COOL;
                cnt   <= CNT_LOAD;
            end else if (state == S_COOL) begin
                if (cnt == '0) begin
                    state <= S_READY;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

    assign vblank = (i_Row_Count == 10'(c_ACTIVE_ROWS))
                 && (i_Col_Count == 10'd0);

    // Displayed cell follows the logical cell only at the vblank point.
    always_ff @(posedge i_Clk or negedge i_Rst_N) begin
        if (!i_Rst_N) begin
            disp_col <= SPAWN_COL;
            disp_row <= SPAWN_ROW;
        end else if (vblank) begin
            disp_col <= col_q;
            disp_row <= row_q;
        end
    end

    assign o_Frog_X = 10'(disp_col) << c_CELL_SHIFT;
    assign o_Frog_Y = 10'(disp_row) << c_CELL_SHIFT;

    frog_sprite_window u_window (
        .i_Clk       (i_Clk),
        .i_Rst_N     (i_Rst_N),
        .i_X         (o_Frog_X),
        .i_Y         (o_Frog_Y),
        .i_Col_Count (i_Col_Count),
        .i_Row_Count (i_Row_Count),
        .o_Draw      (o_Draw_Frog)
    );

endmodule

// File: tb/tb_frog_hop_ctrl.sv
// Directed bench for frog_hop_ctrl with a queue of expected hop pulses.
// Cooldown shortened to 8 clocks.
module tb_frog_hop_ctrl;

    logic       clk;
    logic       rst_n;
    logic       active;
    logic       respawn;
    logic       up;
    logic       dn;
    logic       lt;
    logic       rt;
    logic [9:0] col_cnt;
    logic [9:0] row_cnt;
    logic [9:0] frog_x;
    logic [9:0] frog_y;
    logic       draw;
    logic       hop;
    logic       at_top;

    int checks   = 0;
    int failures = 0;

    string hop_q[$];

    frog_hop_ctrl #(
        .c_ACTIVE_ROWS  (480),
        .c_HOP_COOLDOWN (8)
    ) dut (
        .i_Clk         (clk),
        .i_Rst_N       (rst_n),
        .i_Game_Active (active),
        .i_Respawn     (respawn),
        .i_Up          (up),
        .i_Dn          (dn),
        .i_Lt          (lt),
        .i_Rt          (rt),
        .i_Col_Count   (col_cnt),
        .i_Row_Count   (row_cnt),
        .o_Frog_X      (frog_x),
        .o_Frog_Y      (frog_y),
        .o_Draw_Frog   (draw),
        .o_Hop         (hop),
        .o_At_Top      (at_top)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Every o_Hop pulse must match a hop the stimulus announced.
    always @(posedge clk) begin
        #1;
        if (hop === 1'b1) begin
            checks++;
            assert (hop_q.size() > 0) else begin
                failures++;
                $error("FAIL hop_unexpected observed=1 expected=0");
            end
            if (hop_q.size() > 0) void'(hop_q.pop_front());
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drained(input string tag);
        check(tag, hop_q.size(), 0);
        hop_q.delete();
    endtask

    task automatic vblank();
        row_cnt = 10'd480;
        col_cnt = 10'd0;
        step();
        row_cnt = 10'd0;
        col_cnt = 10'd5;
        step();
    endtask

    // b: 0=up 1=dn 2=lt 3=rt
    task automatic press(input int b, input bit expect_hop,
                         input string tag);
        if (expect_hop) hop_q.push_back(tag);
        case (b)
            0: up = 1'b1;
            1: dn = 1'b1;
            2: lt = 1'b1;
            default: rt = 1'b1;
        endcase
        step();
        up = 1'b0;
        dn = 1'b0;
        lt = 1'b0;
        rt = 1'b0;
        step();
    endtask

    task automatic draw_at(input int c, input int r, input int exp,
                           input string tag);
        col_cnt = 10'(c);
        row_cnt = 10'(r);
        step();
        check(tag, int'(draw), exp);
        col_cnt = 10'd5;
        row_cnt = 10'd0;
    endtask

    initial begin
        rst_n   = 1'b0;
        active  = 1'b0;
        respawn = 1'b0;
        up      = 1'b0;
        dn      = 1'b0;
        lt      = 1'b0;
        rt      = 1'b0;
        col_cnt = 10'd5;
        row_cnt = 10'd0;
        step(3);
        check("rst_x", int'(frog_x), 288);
        check("rst_y", int'(frog_y), 448);
        check("rst_draw", int'(draw), 0);
        check("rst_hop", int'(hop), 0);
        check("rst_top", int'(at_top), 0);
        rst_n = 1'b1;
        step(2);
        check("rel_x", int'(frog_x), 288);
        check("rel_y", int'(frog_y), 448);
        check("rel_draw", int'(draw), 0);

        vblank();
        draw_at(288, 448, 1, "draw_corner");
        draw_at(320, 448, 0, "draw_right_out");
        draw_at(319, 479, 1, "draw_br_in");
        draw_at(288, 447, 0, "draw_above_out");
        draw_at(287, 460, 0, "draw_left_out");

        // Inactive game: edges dropped.
        press(0, 1'b0, "inactive_up");
        step(10);
        vblank();
        check("inactive_y", int'(frog_y), 448);
        drained("inactive_q");

        // Single up hop, display waits for vblank.
        active = 1'b1;
        press(0, 1'b1, "up1");
        check("pre_latch_y", int'(frog_y), 448);
        vblank();
        check("up1_y", int'(frog_y), 416);
        step(10);
        drained("up1_q");

        // Up and Rt together, then Rt inside cooldown.
        hop_q.push_back("up_rt");
        up = 1'b1;
        rt = 1'b1;
        step();
        up = 1'b0;
        rt = 1'b0;
        step(2);
        rt = 1'b1;
        step();
        rt = 1'b0;
        step(12);
        vblank();
        check("prio_y", int'(frog_y), 384);
        check("prio_x", int'(frog_x), 288);
        drained("prio_q");

        // Walk to the right edge, then a clamped Rt.
        for (int i = 0; i < 10; i++) begin
            press(3, 1'b1, "rt_walk");
            step(10);
        end
        vblank();
        check("edge_x", int'(frog_x), 608);
        press(3, 1'b1, "rt_clamp");
        step(10);
        vblank();
        check("clamp_x", int'(frog_x), 608);
        drained("rt_q");

        // Climb from row 12 to row 0.
        for (int i = 0; i < 11; i++) begin
            press(0, 1'b1, "up_climb");
            step(10);
        end
        check("row1_top", int'(at_top), 0);
        press(0, 1'b1, "up_last");
        step(10);
        vblank();
        check("top_y", int'(frog_y), 0);
        check("top_flag", int'(at_top), 1);
        press(0, 1'b1, "up_clamp");
        step(10);
        vblank();
        check("top_clamp_y", int'(frog_y), 0);
        drained("climb_q");

        // Respawn overrides a Dn edge during cooldown.
        press(1, 1'b1, "dn_pre");
        dn = 1'b1;
        respawn = 1'b1;
        step();
        dn = 1'b0;
        respawn = 1'b0;
        step();
        check("resp_top", int'(at_top), 0);
        press(0, 1'b1, "up_after_resp");
        vblank();
        check("resp_x", int'(frog_x), 288);
        check("resp_y", int'(frog_y), 416);
        step(10);
        drained("resp_q");

        // Async reset mid-cooldown and mid-frame.
        press(3, 1'b1, "rt_pre_rst");
        draw_at(290, 420, 1, "pre_rst_draw");
        col_cnt = 10'd290;
        row_cnt = 10'd420;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_x", int'(frog_x), 288);
        check("arst_y", int'(frog_y), 448);
        check("arst_draw", int'(draw), 0);
        check("arst_hop", int'(hop), 0);
        check("arst_top", int'(at_top), 0);
        step(2);
        rst_n = 1'b1;
        col_cnt = 10'd5;
        row_cnt = 10'd0;
        step(12);
        vblank();
        check("post_x", int'(frog_x), 288);
        check("post_y", int'(frog_y), 448);
        drained("post_q");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
